calc_engine: RTL and testbench
==============================

Name:
calc_engine

Overview:
- Parametrised successor of the single-width calculator datapath: accumulator-based chained calculator (pocket-calculator semantics) with operand entry, operator strobes, equals, sticky overflow and divide-by-zero error.
- Sits between button-decode logic (upstream) and bin_num_display (downstream, driven from disp_val).
- Division is multi-cycle via a sequential restoring divider; other ops complete in one EXEC cycle.

Parameters:
- WIDTH, 10, operand/accumulator/result width in bits (unsigned), legal 4..16.
- OP_W, 3, width of op_in encoding (fixed by calc_pkg::op_t).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clr  in  1  synchronous, active-high reset; also the user "clear" function.
- num_valid  in  1  one-cycle strobe, num_in is a new operand entry.
- num_in  in  WIDTH  operand value.
- op_valid  in  1  one-cycle strobe, op_in is an operator/equals press.
- op_in  in  OP_W  calc_pkg::op_t {OP_NONE=0, OP_ADD=1, OP_SUB=2, OP_DIV=3, OP_MUL=4, OP_EQ=5}; others reserved.
- disp_val  out  WIDTH  value for bin_num_display.
- result_valid  out  1  one-cycle pulse when acc is updated by an operation.
- busy  out  1  high while EXEC or DIV_WAIT; strobes are ignored.
- ovf  out  1  sticky overflow/borrow flag.
- err  out  1  divide-by-zero error, held until clr.

Behaviour:
- Reset (clr=1 at an edge, any state, including mid-divide): state=IDLE, acc=0, entry=0, pend_op=OP_NONE, disp_val=0, result_valid=0, busy=0, ovf=0, err=0; divider aborted.
- Internal regs: acc (WIDTH), entry (WIDTH), pend_op (op_t), cur_op (op_t).
- States: IDLE, EXEC, DIV_WAIT, ERROR.
- IDLE, num_valid: entry<=num_in; disp_val<=num_in; stays IDLE.
- IDLE, op_valid with op_in in {ADD,SUB,MUL,DIV,EQ}: cur_op<=op_in; goto EXEC. Reserved/OP_NONE codes ignored.
- Simultaneous num_valid+op_valid in IDLE: num_in is written to entry AND used as the operand of the EXEC (bypass); equivalent to the number arriving one cycle earlier.
- EXEC (one cycle): computes acc' = acc pend_op entry:
  - OP_NONE: acc'=entry (first operand of a chain).
  - ADD: acc+entry mod 2^WIDTH; ovf|=carry.
  - SUB: acc-entry mod 2^WIDTH; ovf|=borrow (entry>acc).
  - MUL: low WIDTH bits of the 2*WIDTH product; ovf|=any high bit set.
  - DIV: entry==0 -> goto ERROR; else start divider, goto DIV_WAIT.
  - Non-DIV: acc<=acc', disp_val<=acc', result_valid=1 on the following cycle, pend_op<=(cur_op==EQ ? OP_NONE : cur_op), goto IDLE.
  - After EQ, the next op press chains from acc: entry<=acc on EQ so OP_NONE reload keeps the result.
- Operand order is fixed: acc is the left operand (acc-entry, acc/entry).
- DIV_WAIT: divider runs exactly WIDTH cycles; on done acc<=quotient (remainder discarded), disp_val updated, pend_op update as above, goto IDLE. ovf unaffected.
- Latency (strobe sampled at edge N): non-DIV result on disp_val and result_valid high after edge N+2; DIV result after edge N+2+WIDTH.
- busy=1 in EXEC and DIV_WAIT; num_valid/op_valid ignored (dropped, not queued) while busy.
- ERROR: err=1, disp_val={WIDTH{1'b1}}, all strobes ignored; exit only via clr.
- ovf is cleared only by clr.

Decomposition:
- calc_pkg: op_t enum, state_t enum, OP_W localparam.
- Sub-module seq_divider #(WIDTH): start/dividend/divisor in, busy/done/quotient/remainder out, restoring algorithm, one quotient bit per cycle, synchronous clr abort.
- calc_engine holds FSM, acc/entry regs, ADD/SUB/MUL datapath, flags.

Test Plan:
- WIDTH=10: num 12, ADD, num 30, EQ -> disp_val=42, result_valid pulse 2 cycles after the EQ strobe, ovf=0.
- num 5, SUB, num 7, EQ -> disp_val=1022, ovf=1; further num 3, ADD, num 1, EQ -> 4, ovf still 1.
- num 1000, MUL, num 2, EQ -> disp_val=976, ovf=1; chain MUL, num 1, EQ -> 976.
- num 100, DIV, num 7, EQ -> busy high 11 cycles, disp_val=14 at strobe+12; strobes during busy have no effect.
- num 9, DIV, num 0, EQ -> err=1, disp_val=1023, num/op strobes ignored; clr -> all outputs 0, state IDLE.
- clr asserted mid-divide (cycle 5 of DIV_WAIT) -> next cycle busy=0, acc=0, no result_valid pulse; simultaneous num 6 + ADD after num 4, ADD -> acc=10.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared operator/state encodings for the calculator engine.
package calc_pkg;
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_DIV  = 3'd3,
        OP_MUL  = 3'd4,
        OP_EQ   = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DIV_WAIT,
        S_ERROR
    } state_t;

    function automatic logic is_op(input logic [OP_W-1:0] code);
        return (code >= 3'd1) && (code <= 3'd5);
    endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle.
// The first bit is resolved on the start edge, so done pulses WIDTH edges after start.
module seq_divider #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q;
    logic [WIDTH-1:0] src_r, src_q, src_d;
    logic [WIDTH:0]   trial, rem_next;
    logic             ge, step;

    always_comb begin
        src_r    = start ? '0 : rem_q;
        src_q    = start ? dividend : quo_q;
        src_d    = start ? divisor : dvs_q;
        trial    = {src_r, src_q[WIDTH-1]};
        ge       = trial >= {1'b0, src_d};
        rem_next = ge ? trial - {1'b0, src_d} : trial;
        step     = start || (cnt_q != '0);
        cnt_d    = start ? CW'(WIDTH - 1) : (cnt_q != '0 ? cnt_q - 1'b1 : '0);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= step && (cnt_d == '0);
            if (step) begin
                rem_q <= rem_next[WIDTH-1:0];
                quo_q <= {src_q[WIDTH-2:0], ge};
                dvs_q <= src_d;
            end
        end
    end

    assign busy      = cnt_q != '0;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/calc_engine.sv
// calc_engine: accumulator-based chained calculator with sticky overflow and
// divide-by-zero lockout; results reach disp_val one cycle after acc commits.
module calc_engine #(
    parameter int WIDTH = 10,
    parameter int OP_W  = calc_pkg::OP_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             num_valid,
    input  logic [WIDTH-1:0] num_in,
    input  logic             op_valid,
    input  logic [OP_W-1:0]  op_in,
    output logic [WIDTH-1:0] disp_val,
    output logic             result_valid,
    output logic             busy,
    output logic             ovf,
    output logic             err
);
    import calc_pkg::*;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, entry_q, entry_d, disp_q, disp_d;
    op_t              pend_q, pend_d, cur_q, cur_d;
    logic             ovf_q, ovf_d, rv_q, rv_d, upd_q, upd_d;
    logic [WIDTH:0]   sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] alu_val, res;
    logic             alu_ovf, in_idle, op_take, div_start, div_done, commit;
    logic [WIDTH-1:0] div_quo, div_rem_unused;
    logic             div_busy_unused;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .clr      (clr),
        .start    (div_start),
        .dividend (acc_q),
        .divisor  (entry_q),
        .busy     (div_busy_unused),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem_unused)
    );

    always_ff @(posedge clk) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = op_take ? S_EXEC : S_IDLE;
            S_EXEC:     state_d = pend_q != OP_DIV ? S_IDLE : (entry_q == '0 ? S_ERROR : S_DIV_WAIT);
            S_DIV_WAIT: state_d = div_done ? S_IDLE : S_DIV_WAIT;
            default:    state_d = S_ERROR;
        endcase
    end

    always_comb begin
        in_idle      = state_q == S_IDLE;
        op_take      = in_idle && op_valid && is_op(op_in);
        busy         = (state_q == S_EXEC) || (state_q == S_DIV_WAIT);
        err          = state_q == S_ERROR;
        div_start    = (state_q == S_EXEC) && (pend_q == OP_DIV) && (entry_q != '0);
        commit       = ((state_q == S_EXEC) && (pend_q != OP_DIV)) || ((state_q == S_DIV_WAIT) && div_done);
        disp_val     = err ? '1 : disp_q;
        result_valid = rv_q;
        ovf          = ovf_q;
    end

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, entry_q};
        diff    = {1'b0, acc_q} - {1'b0, entry_q};
        prod    = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, entry_q};
        alu_val = pend_q == OP_ADD ? sum[WIDTH-1:0] :
                  pend_q == OP_SUB ? diff[WIDTH-1:0] :
                  pend_q == OP_MUL ? prod[WIDTH-1:0] : entry_q;
        alu_ovf = pend_q == OP_ADD ? sum[WIDTH] :
                  pend_q == OP_SUB ? diff[WIDTH] :
                  pend_q == OP_MUL ? |prod[2*WIDTH-1:WIDTH] : 1'b0;
        res     = state_q == S_EXEC ? alu_val : div_quo;
    end

    // Simultaneous number+operator works because entry is written on the same edge that enters EXEC.
    always_comb begin
        acc_d   = acc_q;
        entry_d = entry_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        ovf_d   = ovf_q;
        upd_d   = commit;
        rv_d    = upd_q;
        disp_d  = upd_q ? acc_q : disp_q;
        if (in_idle && num_valid) begin
            entry_d = num_in;
            disp_d  = num_in;
        end
        if (op_take) cur_d = op_t'(op_in);
        if (commit) begin
            acc_d   = res;
            pend_d  = cur_q == OP_EQ ? OP_NONE : cur_q;
            entry_d = cur_q == OP_EQ ? res : entry_q;
            ovf_d   = ovf_q | ((state_q == S_EXEC) && alu_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc_q   <= '0;
            entry_q <= '0;
            disp_q  <= '0;
            pend_q  <= OP_NONE;
            cur_q   <= OP_NONE;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            entry_q <= entry_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            ovf_q   <= ovf_d;
            rv_q    <= rv_d;
            upd_q   <= upd_d;
        end
    end
endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed scoreboard bench; stimulus queues expected results,
// a negedge monitor pops one entry per result_valid pulse.
module tb_calc_engine;
    import calc_pkg::*;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         num_valid = 1'b0;
    logic         op_valid = 1'b0;
    logic [W-1:0] num_in = '0;
    logic [2:0]   op_in = '0;
    logic [W-1:0] disp_val;
    logic         result_valid, busy, ovf, err;

    typedef struct {
        int val;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    calc_engine #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .num_valid   (num_valid),
        .num_in      (num_in),
        .op_valid    (op_valid),
        .op_in       (op_in),
        .disp_val    (disp_val),
        .result_valid(result_valid),
        .busy        (busy),
        .ovf         (ovf),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (result_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("result_val", int'(disp_val), e.val);
                chk("result_ovf", int'(ovf), e.ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_num(input int v);
        num_valid = 1'b1;
        num_in = W'(v);
        tick();
        num_valid = 1'b0;
    endtask

    task automatic put_op(input op_t o, input int v, input int ov);
        op_valid = 1'b1;
        op_in = o;
        sb.push_back('{val: v, ovf: ov});
        tick();
        op_valid = 1'b0;
    endtask

    task automatic put_op_nr(input op_t o);
        op_valid = 1'b1;
        op_in = o;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("busy_timeout", 1, 0);
        tick();
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        tick();
        tick();
        chk("rst_disp", int'(disp_val), 0);
        chk("rst_rv", int'(result_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_err", int'(err), 0);
        clr = 1'b0;

        put_num(12);
        put_op(OP_ADD, 12, 0);
        settle();
        put_num(30);
        chk("num_disp", int'(disp_val), 30);
        put_op(OP_EQ, 42, 0);
        tick();
        chk("lat_n1_rv", int'(result_valid), 0);
        tick();
        chk("lat_n2_rv", int'(result_valid), 1);
        chk("add_disp", int'(disp_val), 42);
        settle();
        do_clr();

        put_num(5);
        put_op(OP_SUB, 5, 0);
        settle();
        put_num(7);
        put_op(OP_EQ, 1022, 1);
        settle();
        put_num(3);
        put_op(OP_ADD, 3, 1);
        settle();
        put_num(1);
        put_op(OP_EQ, 4, 1);
        settle();
        chk("ovf_sticky", int'(ovf), 1);
        do_clr();

        put_num(1000);
        put_op(OP_MUL, 1000, 0);
        settle();
        put_num(2);
        put_op(OP_EQ, 976, 1);
        settle();
        put_op(OP_MUL, 976, 1);
        settle();
        put_num(1);
        put_op(OP_EQ, 976, 1);
        settle();
        do_clr();

        put_num(100);
        put_op(OP_DIV, 100, 0);
        settle();
        put_num(7);
        put_op(OP_EQ, 14, 0);
        bc = 0;
        @(negedge clk);
        while (busy && bc < 40) begin
            bc++;
            if (bc == 3) begin
                num_valid = 1'b1;
                num_in = W'(55);
                op_valid = 1'b1;
                op_in = OP_ADD;
            end else begin
                num_valid = 1'b0;
                op_valid = 1'b0;
            end
            @(negedge clk);
        end
        num_valid = 1'b0;
        op_valid = 1'b0;
        chk("div_busy_cycles", bc, 11);
        @(posedge clk);
        #1;
        chk("div_rv", int'(result_valid), 1);
        chk("div_disp", int'(disp_val), 14);
        settle();
        put_op(OP_ADD, 14, 0);
        settle();
        do_clr();

        put_num(9);
        put_op(OP_DIV, 9, 0);
        settle();
        put_num(0);
        put_op_nr(OP_EQ);
        tick();
        tick();
        chk("dz_err", int'(err), 1);
        chk("dz_disp", int'(disp_val), 1023);
        put_num(5);
        put_op_nr(OP_ADD);
        tick();
        tick();
        chk("dz_err_held", int'(err), 1);
        chk("dz_disp_held", int'(disp_val), 1023);
        chk("dz_busy", int'(busy), 0);
        do_clr();
        chk("clr_disp", int'(disp_val), 0);
        chk("clr_err", int'(err), 0);
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_rv", int'(result_valid), 0);
        put_num(8);
        chk("clr_idle_num", int'(disp_val), 8);

        do_clr();
        put_num(50);
        put_op(OP_DIV, 50, 0);
        settle();
        put_num(5);
        put_op_nr(OP_EQ);
        for (int i = 0; i < 4; i++) tick();
        chk("abort_busy_before", int'(busy), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_disp", int'(disp_val), 0);
        chk("abort_rv", int'(result_valid), 0);
        for (int i = 0; i < 15; i++) tick();
        put_num(4);
        put_op(OP_ADD, 4, 0);
        settle();
        num_valid = 1'b1;
        num_in = W'(6);
        op_valid = 1'b1;
        op_in = OP_ADD;
        sb.push_back('{val: 10, ovf: 0});
        tick();
        num_valid = 1'b0;
        op_valid = 1'b0;
        settle();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
